// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared Wishbone register-file types, widths and byte merge.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;

  // Slave sequencing: accept, optional wait states, one-cycle termination.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    TERM = 2'd2
  } state_t;

  // Kind of termination returned to the master.
  typedef enum logic [1:0] {
    RSP_ACK = 2'd0,
    RSP_ERR = 2'd1,
    RSP_RTY = 2'd2
  } rsp_t;

  // Replace the selected byte lanes of old_w with those of new_w.
  function automatic logic [WB_DW-1:0] byte_merge(
    input logic [WB_DW-1:0]   old_w,
    input logic [WB_DW-1:0]   new_w,
    input logic [WB_SELW-1:0] sel
  );
    logic [WB_DW-1:0] merged;
    merged = old_w;
    for (int n = 0; n < WB_SELW; n++) begin
      if (sel[n]) begin
        merged[8*n +: 8] = new_w[8*n +: 8];
      end
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_regfile_array.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_array
// Description : DEPTH x 32-bit storage, async clear, byte-enabled write port,
//               combinational read port.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile_array
  import wb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IW    = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [IW-1:0]        waddr_i,
  input  logic [WB_SELW-1:0]   sel_i,
  input  logic [WB_DW-1:0]     wdata_i,
  input  logic [IW-1:0]        raddr_i,
  output logic [WB_DW-1:0]     rdata_o
);

  logic [WB_DW-1:0] mem_q [DEPTH];

  // Storage: cleared by reset, byte lanes updated on a write strobe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= byte_merge(mem_q[waddr_i], wdata_i, sel_i);
    end
  end

  // Read port: the top only reads addresses already checked to be in range.
  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule
`default_nettype wire

// File: rtl/wb_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_slave
// Description : Wishbone classic 32-bit slave in front of a byte-writable
//               register file, with ACK/ERR/RTY and programmable wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile_slave
  import wb_pkg::*;
#(
  parameter int AW          = 8,
  parameter int DEPTH       = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic                 CYC_I,
  input  logic                 STB_I,
  input  logic                 WE_I,
  input  logic [AW-1:0]        ADR_I,
  input  logic [WB_SELW-1:0]   SEL_I,
  input  logic [WB_DW-1:0]     DAT_I,
  output logic [WB_DW-1:0]     DAT_O,
  output logic                 ACK_O,
  output logic                 ERR_O,
  output logic                 RTY_O,
  input  logic [3:0]           TAG_I,
  output logic [3:0]           TAG_O,
  input  logic                 HOLD_I
);

  localparam int            IW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-2:0] C_DEPTH     = DEPTH[AW-2:0];
  // The counter is preloaded so that the access edge lands WAIT_STATES
  // edges after the accepting edge.
  localparam logic [3:0]    C_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q,   cnt_d;
  logic              ack_q,   ack_d;
  logic              err_q,   err_d;
  logic              rty_q,   rty_d;
  logic [3:0]        tag_q,   tag_d;
  logic [WB_DW-1:0]  dat_q,   dat_d;

  logic [AW-3:0]     w_idx;
  logic [IW-1:0]     w_widx;
  logic              w_req;
  logic              w_in_range;
  logic              w_access;
  logic              w_term;
  rsp_t              w_rsp;
  logic              w_we;
  logic [WB_DW-1:0]  w_rdata;
  logic              w_unused_adr;

  assign w_idx        = ADR_I[AW-1:2];
  assign w_widx       = w_idx[IW-1:0];
  assign w_req        = CYC_I & STB_I;
  assign w_in_range   = ({1'b0, w_idx} < C_DEPTH);
  assign w_we         = w_access & WE_I;
  assign w_unused_adr = &{1'b0, ADR_I[1:0]};

  wb_regfile_array #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_array (
    .clk_i   (CLK_I),
    .rst_i   (RST_I),
    .we_i    (w_we),
    .waddr_i (w_widx),
    .sel_i   (SEL_I),
    .wdata_i (DAT_I),
    .raddr_i (w_widx),
    .rdata_o (w_rdata)
  );

  // State, counter and every output register; reset is asynchronous.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
      tag_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rty_q   <= rty_d;
      tag_q   <= tag_d;
      dat_q   <= dat_d;
    end
  end

  // Next state, access decision and termination selection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tag_d    = tag_q;
    dat_d    = dat_q;
    w_access = 1'b0;
    w_term   = 1'b0;
    w_rsp    = RSP_ACK;

    case (state_q)
      IDLE: begin
        if (w_req) begin
          tag_d = TAG_I;
          if (HOLD_I) begin
            w_rsp   = RSP_RTY;
            w_term  = 1'b1;
            state_d = TERM;
          end else if (!w_in_range) begin
            w_rsp   = RSP_ERR;
            w_term  = 1'b1;
            state_d = TERM;
          end else if (WAIT_STATES == 0) begin
            w_access = 1'b1;
            w_term   = 1'b1;
            state_d  = TERM;
          end else begin
            cnt_d   = C_WAIT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!w_req) begin
          // Master abandoned the transfer: nothing is written or returned.
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          w_access = 1'b1;
          w_term   = 1'b1;
          state_d  = TERM;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      TERM: begin
        // The strobe still high here belongs to the finished transfer.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (w_access && !WE_I) begin
      dat_d = w_rdata;
    end

    ack_d = w_term && (w_rsp == RSP_ACK);
    err_d = w_term && (w_rsp == RSP_ERR);
    rty_d = w_term && (w_rsp == RSP_RTY);
  end

  assign DAT_O = dat_q;
  assign ACK_O = ack_q;
  assign ERR_O = err_q;
  assign RTY_O = rty_q;
  assign TAG_O = tag_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_regfile_slave
// Description : Self-checking bench; two slaves (0 and 3 wait states) driven
//               by a behavioural master and checked against a word model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cyc, stb;
  logic        we;
  logic [7:0]  adr;
  logic [3:0]  sel;
  logic [31:0] wdat;
  logic [3:0]  tag;
  logic        hold;

  logic [31:0] dat_o [2];
  logic [1:0]  ack_o, err_o, rty_o;
  logic [3:0]  tag_o [2];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem_m [2][8];
  logic [31:0] last_rd [2];
  int          ws [2] = '{0, 3};

  always #5 clk = ~clk;

  wb_regfile_slave #(.AW(8), .DEPTH(8), .WAIT_STATES(0)) u_dut0 (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc[0]), .STB_I(stb[0]), .WE_I(we),
    .ADR_I(adr), .SEL_I(sel), .DAT_I(wdat), .DAT_O(dat_o[0]),
    .ACK_O(ack_o[0]), .ERR_O(err_o[0]), .RTY_O(rty_o[0]),
    .TAG_I(tag), .TAG_O(tag_o[0]), .HOLD_I(hold)
  );

  wb_regfile_slave #(.AW(8), .DEPTH(8), .WAIT_STATES(3)) u_dut1 (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc[1]), .STB_I(stb[1]), .WE_I(we),
    .ADR_I(adr), .SEL_I(sel), .DAT_I(wdat), .DAT_O(dat_o[1]),
    .ACK_O(ack_o[1]), .ERR_O(err_o[1]), .RTY_O(rty_o[1]),
    .TAG_I(tag), .TAG_O(tag_o[1]), .HOLD_I(hold)
  );

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) mem_m[d][i] = 32'h0;
      last_rd[d] = 32'h0;
    end
  endtask

  // One complete Wishbone transfer on slave d, checked against the model.
  // chain keeps STB high across the termination edge (next transfer follows).
  task automatic do_xfer(input int d, input bit we_v, input logic [7:0] a,
                         input logic [3:0] s, input logic [31:0] wd,
                         input logic [3:0] t, input bit h, input bit chain,
                         input bit keep_cyc);
    int          idx, n, rsp_e, rsp_a, lat_e;
    logic [31:0] dat_e, mask;
    bit          done;
    idx = int'(a[7:2]);
    if (h)             rsp_e = 2;
    else if (idx >= 8) rsp_e = 1;
    else               rsp_e = 0;
    lat_e = (rsp_e == 0) ? ws[d] + 1 : 1;
    dat_e = last_rd[d];
    if (rsp_e == 0 && !we_v) dat_e = mem_m[d][idx];

    we = we_v; adr = a; sel = s; wdat = wd; tag = t; hold = h;
    cyc[1-d] = 1'b0; stb[1-d] = 1'b0;
    cyc[d]   = 1'b1; stb[d]   = 1'b1;

    done = 1'b0; n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ack_o[d] | err_o[d] | rty_o[d]) done = 1'b1;
    end

    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL xfer_timeout d=%0d adr=%h: no termination after %0d edges", d, a, n);
    end else begin
      rsp_a = ack_o[d] ? 0 : (err_o[d] ? 1 : 2);
      n_checks++;
      if ((int'(ack_o[d]) + int'(err_o[d]) + int'(rty_o[d])) != 1) begin
        n_fail++;
        $display("FAIL onehot d=%0d: ack=%b err=%b rty=%b, want exactly one", d, ack_o[d], err_o[d], rty_o[d]);
      end
      n_checks++;
      if (rsp_a !== rsp_e) begin
        n_fail++;
        $display("FAIL rsp_type d=%0d adr=%h: got %0d want %0d (0=ACK 1=ERR 2=RTY)", d, a, rsp_a, rsp_e);
      end
      n_checks++;
      if (n !== lat_e) begin
        n_fail++;
        $display("FAIL latency d=%0d adr=%h: got %0d edges want %0d", d, a, n, lat_e);
      end
      n_checks++;
      if (tag_o[d] !== t) begin
        n_fail++;
        $display("FAIL tag d=%0d: got %h want %h", d, tag_o[d], t);
      end
      n_checks++;
      if (dat_o[d] !== dat_e) begin
        n_fail++;
        $display("FAIL dat_o d=%0d adr=%h we=%b: got %h want %h", d, a, we_v, dat_o[d], dat_e);
      end
    end

    if (!chain) begin
      stb[d] = 1'b0;
      if (!keep_cyc) cyc[d] = 1'b0;
    end
    @(posedge clk); #1;
    n_checks++;
    if (ack_o[d] | err_o[d] | rty_o[d]) begin
      n_fail++;
      $display("FAIL strobe_width d=%0d: ack=%b err=%b rty=%b after termination cycle, want 0",
               d, ack_o[d], err_o[d], rty_o[d]);
    end

    if (rsp_e == 0 && we_v) begin
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      mem_m[d][idx] = (mem_m[d][idx] & ~mask) | (wd & mask);
    end
    last_rd[d] = dat_e;
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc = '0; stb = '0; we = 1'b0; adr = '0; sel = '0;
    wdat = '0; tag = '0; hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (dat_o[d] !== 32'h0 || tag_o[d] !== 4'h0 || ack_o[d] || err_o[d] || rty_o[d]) begin
        n_fail++;
        $display("FAIL reset_outputs d=%0d: dat=%h tag=%h a/e/r=%b%b%b, want all zero",
                 d, dat_o[d], tag_o[d], ack_o[d], err_o[d], rty_o[d]);
      end
    end
    @(negedge clk); rst = 1'b0;
    clear_model();
    for (int d = 0; d < 2; d++) do_xfer(d, 1'b0, 8'h1C, 4'hF, 32'h0, 4'h3, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_single();
    do_xfer(0, 1'b1, 8'h04, 4'hF, 32'hDEADBEEF, 4'h5, 1'b0, 1'b0, 1'b0);
    do_xfer(0, 1'b0, 8'h04, 4'h0, 32'h0, 4'hA, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (dat_o[0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL single_rd: got %h want DEADBEEF", dat_o[0]);
    end
  endtask

  task automatic test_byte_sel();
    for (int d = 0; d < 2; d++) begin
      do_xfer(d, 1'b1, 8'h08, 4'hF, 32'h11223344, 4'h1, 1'b0, 1'b0, 1'b0);
      do_xfer(d, 1'b1, 8'h0A, 4'b0101, 32'hAABBCCDD, 4'h2, 1'b0, 1'b0, 1'b0);
      do_xfer(d, 1'b0, 8'h08, 4'h0, 32'h0, 4'h3, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (dat_o[d] !== 32'h11BB33DD) begin
        n_fail++;
        $display("FAIL byte_sel d=%0d: got %h want 11BB33DD", d, dat_o[d]);
      end
      do_xfer(d, 1'b1, 8'h08, 4'h0, 32'hFFFFFFFF, 4'h4, 1'b0, 1'b0, 1'b0);
      do_xfer(d, 1'b0, 8'h08, 4'hF, 32'h0, 4'h5, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_wait_abort();
    bit seen;
    do_xfer(1, 1'b0, 8'h00, 4'hF, 32'h0, 4'h6, 1'b0, 1'b0, 1'b0);
    do_xfer(1, 1'b1, 8'h04, 4'hF, 32'h0BADF00D, 4'h7, 1'b0, 1'b0, 1'b0);
    do_xfer(1, 1'b0, 8'h08, 4'hF, 32'h0, 4'h8, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      we = (k == 1); adr = 8'h04; sel = 4'hF; wdat = $urandom; tag = 4'hC; hold = 1'b0;
      cyc[1] = 1'b1; stb[1] = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      cyc[1] = 1'b0; stb[1] = 1'b0;
      seen = 1'b0;
      repeat (6) begin
        @(posedge clk); #1;
        if (ack_o[1] | err_o[1] | rty_o[1]) seen = 1'b1;
      end
      n_checks++;
      if (seen) begin
        n_fail++;
        $display("FAIL abort_strobe k=%0d: got termination want none", k);
      end
      n_checks++;
      if (dat_o[1] !== last_rd[1]) begin
        n_fail++;
        $display("FAIL abort_dat k=%0d: got %h want %h", k, dat_o[1], last_rd[1]);
      end
      do_xfer(1, 1'b0, 8'h04, 4'hF, 32'h0, 4'h9, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_err_rty();
    for (int d = 0; d < 2; d++) begin
      do_xfer(d, 1'b0, 8'h20, 4'hF, 32'h0, 4'hB, 1'b0, 1'b0, 1'b0);
      do_xfer(d, 1'b1, 8'h04, 4'hF, 32'h55555555, 4'hC, 1'b1, 1'b0, 1'b0);
      do_xfer(d, 1'b0, 8'h20, 4'hF, 32'h0, 4'hD, 1'b1, 1'b0, 1'b0);
      do_xfer(d, 1'b1, 8'hFC, 4'hF, 32'h66666666, 4'hE, 1'b0, 1'b0, 1'b0);
      do_xfer(d, 1'b0, 8'h04, 4'hF, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v [4];
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        v[i] = $urandom;
        do_xfer(d, 1'b1, 8'(i * 4), 4'hF, v[i], 4'(i), 1'b0, i < 3, i < 3);
      end
      for (int i = 0; i < 4; i++) begin
        do_xfer(d, 1'b0, 8'(i * 4), 4'hF, 32'h0, 4'(i + 8), 1'b0, i < 3, i < 3);
        n_checks++;
        if (dat_o[d] !== v[i]) begin
          n_fail++;
          $display("FAIL block_rd d=%0d i=%0d: got %h want %h", d, i, dat_o[d], v[i]);
        end
      end
    end
  endtask

  task automatic test_rmw();
    for (int d = 0; d < 2; d++) begin
      do_xfer(d, 1'b1, 8'h10, 4'hF, 32'h5, 4'h1, 1'b0, 1'b0, 1'b0);
      do_xfer(d, 1'b0, 8'h10, 4'hF, 32'h0, 4'h2, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (dat_o[d] !== 32'h5) begin
        n_fail++;
        $display("FAIL rmw_read d=%0d: got %h want 00000005", d, dat_o[d]);
      end
      do_xfer(d, 1'b1, 8'h10, 4'hF, 32'h7, 4'h3, 1'b0, 1'b0, 1'b0);
      do_xfer(d, 1'b0, 8'h10, 4'hF, 32'h0, 4'h4, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (dat_o[d] !== 32'h7) begin
        n_fail++;
        $display("FAIL rmw_after d=%0d: got %h want 00000007", d, dat_o[d]);
      end
    end
  endtask

  task automatic test_random();
    int          d, r;
    logic [7:0]  a;
    for (int k = 0; k < 80; k++) begin
      d = int'($urandom_range(0, 1));
      r = int'($urandom_range(0, 11));
      a = 8'(r * 4 + int'($urandom_range(0, 3)));
      do_xfer(d, 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, 4'($urandom),
              $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic test_reset_midcycle();
    do_xfer(1, 1'b1, 8'h0C, 4'hF, 32'hCAFEF00D, 4'hA, 1'b0, 1'b0, 1'b0);
    do_xfer(1, 1'b0, 8'h0C, 4'hF, 32'h0, 4'h9, 1'b0, 1'b0, 1'b0);
    we = 1'b1; adr = 8'h0C; sel = 4'hF; wdat = 32'h12345678; tag = 4'h6; hold = 1'b0;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    n_checks++;
    if (dat_o[1] !== 32'h0 || tag_o[1] !== 4'h0 || ack_o[1] || err_o[1] || rty_o[1]) begin
      n_fail++;
      $display("FAIL reset_mid: dat=%h tag=%h a/e/r=%b%b%b, want all zero",
               dat_o[1], tag_o[1], ack_o[1], err_o[1], rty_o[1]);
    end
    cyc = '0; stb = '0;
    @(negedge clk); rst = 1'b0;
    clear_model();
    do_xfer(1, 1'b0, 8'h0C, 4'hF, 32'h0, 4'h2, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (dat_o[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_discard: got %h want 00000000", dat_o[1]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_byte_sel();
    test_wait_abort();
    test_err_rty();
    test_back_to_back();
    test_rmw();
    test_random();
    test_reset_midcycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
